// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 CHIP-8 hex keypad scanner.
// Holds the matrix-to-key-code map, matrix dimensions and the key-code type.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = 16;

  typedef logic [3:0] key_code_t;

  // Nibble i holds the key code for matrix index i = row*4 + col (row0 = 1,2,3,C ... row3 = A,0,B,F)
  localparam logic [63:0] KEYMAP = 64'hFB0A_E987_D654_C321;

  function automatic key_code_t key_of(input int row, input int col);
    return KEYMAP[(row * NUM_COLS + col) * 4 +: 4];
  endfunction

  function automatic key_code_t lowest_key(input logic [NUM_KEYS-1:0] keys);
    key_code_t code;
    code = 4'h0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) begin
        code = 4'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key frame-based debouncer: the debounced bit flips only after the raw
// value has differed from it on DEBOUNCE_SCANS consecutive update strobes.
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_W          = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic update,
  input  logic raw,
  output logic state,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             flip;

  // rise marks a released->held flip so the top can build the press set
  always_comb begin
    differ = raw ^ state;
    flip   = update & differ & (cnt == CNT_LAST);
    rise   = flip & ~state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (update) begin
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt   <= cnt;
      state <= state;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad front end: synchronizes rows, assembles a raw
// frame indexed by CHIP-8 key code, debounces each key and flags new presses.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                press_valid,
  output logic [3:0]          press_code,
  output logic                frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] row_sync1;
  logic [NUM_ROWS-1:0] row_sync2;
  logic [DIV_W-1:0]    div;
  logic [1:0]          col_idx;
  logic [1:0]          col_next;
  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] raw_next;
  logic [NUM_KEYS-1:0] rise;
  logic                sample;
  logic                frame_end;
  key_code_t           code;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_sync1 <= 4'hF;
      row_sync2 <= 4'hF;
    end else begin
      row_sync1 <= row_n;
      row_sync2 <= row_sync1;
    end
  end

  // The debouncers see the frame including the column being sampled this cycle
  always_comb begin
    sample    = (div == DIV_LAST);
    frame_end = sample && (col_idx == 2'd3);
    col_next  = col_idx + 2'd1;
    raw_next  = raw;
    code      = 4'h0;
    if (sample) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        code           = KEYMAP[(r * NUM_COLS + int'(col_idx)) * 4 +: 4];
        raw_next[code] = ~row_sync2[r];
      end
    end else begin
      raw_next = raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      col_idx <= 2'd0;
      col_n   <= 4'b1110;
      raw     <= '0;
    end else if (sample) begin
      div     <= '0;
      col_idx <= col_next;
      col_n   <= ~(4'b0001 << col_next);
      raw     <= raw_next;
    end else begin
      div     <= div + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .CNT_W          (CNT_W)
    ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .update (frame_end),
      .raw    (raw_next[k]),
      .state  (key_state[k]),
      .rise   (rise[k])
    );
  end

  // Press events and the frame strobe land together with the key_state update
  always_ff @(posedge clk) begin
    if (rst) begin
      press_valid <= 1'b0;
      press_code  <= 4'h0;
      frame_done  <= 1'b0;
    end else begin
      press_valid <= |rise;
      frame_done  <= frame_end;
      if (|rise) begin
        press_code <= lowest_key(rise);
      end else begin
        press_code <= press_code;
      end
    end
  end

endmodule
